// File: rtl/sifive_insight_tl_d_arbiter.sv
// TileLink D-channel response merger.
//
// Handshake: a beat transfers on a source port when in_valid[i] & in_ready[i]
// are both high at the rising clock edge, and on the merged port when
// out_valid & out_ready are both high. A source that raises valid must hold
// it (and its fields) stable until the beat transfers. in_ready[i] is only
// ever high for the granted source and only when the sink is ready.
//
// Arbitration is round-robin at message boundaries. Multi-beat data messages
// lock the grant until their last beat, so bursts never interleave. busy
// mirrors the FSM state (high only in BURST).
module sifive_insight_tl_d_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = 32,
  parameter int SRC_W    = 4,
  parameter int ECHO_W   = 2,
  parameter int SIZE_W   = 4,
  parameter int LG_BEAT  = 2,
  parameter int MAX_SIZE = 6
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         in_valid,
  output logic [N_REQ-1:0]         in_ready,
  input  logic [N_REQ*3-1:0]       in_opcode,
  input  logic [N_REQ*SIZE_W-1:0]  in_size,
  input  logic [N_REQ*SRC_W-1:0]   in_source,
  input  logic [N_REQ*DATA_W-1:0]  in_data,
  input  logic [N_REQ*ECHO_W-1:0]  in_echo,
  input  logic [N_REQ-1:0]         in_denied,
  input  logic [N_REQ-1:0]         in_corrupt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_opcode,
  output logic [SIZE_W-1:0]        out_size,
  output logic [SRC_W-1:0]         out_source,
  output logic [DATA_W-1:0]        out_data,
  output logic [ECHO_W-1:0]        out_echo,
  output logic                     out_denied,
  output logic                     out_corrupt,
  output logic [N_REQ-1:0]         out_grant,
  output logic                     busy,
  output logic                     err_size
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Wide enough for 2^(MAX_SIZE-LG_BEAT)-1 remaining beats without wrapping.
  localparam int BL_W  = MAX_SIZE - LG_BEAT + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [BL_W-1:0]  beats_left_q, beats_left_d;
  logic [IDX_W-1:0] win_idx, sel_idx;
  logic             win_found, sel_act, fire, oversize;
  logic [BL_W-1:0]  msg_beats_m1;
  int               scan_j, size_i, eff_size;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == N_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Round-robin winner: first valid source scanning cyclically from rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_j    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_j = int'(rr_ptr_q) + k;
      if (scan_j >= N_REQ) scan_j = scan_j - N_REQ;
      if (!win_found && in_valid[scan_j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_j);
      end
    end
  end

  // Grant selection and field mux; everything is zero when nothing is selected.
  always_comb begin
    sel_idx     = (state_q == BURST) ? lock_idx_q : win_idx;
    sel_act     = reset_n & ((state_q == BURST) | win_found);
    out_grant   = '0;
    out_valid   = 1'b0;
    out_opcode  = '0;
    out_size    = '0;
    out_source  = '0;
    out_data    = '0;
    out_echo    = '0;
    out_denied  = 1'b0;
    out_corrupt = 1'b0;
    if (sel_act) begin
      out_grant[sel_idx] = 1'b1;
      out_valid   = in_valid[sel_idx];
      out_opcode  = in_opcode[int'(sel_idx)*3 +: 3];
      out_size    = in_size[int'(sel_idx)*SIZE_W +: SIZE_W];
      out_source  = in_source[int'(sel_idx)*SRC_W +: SRC_W];
      out_data    = in_data[int'(sel_idx)*DATA_W +: DATA_W];
      out_echo    = in_echo[int'(sel_idx)*ECHO_W +: ECHO_W];
      out_denied  = in_denied[sel_idx];
      out_corrupt = in_corrupt[sel_idx];
    end
  end

  assign in_ready = {N_REQ{out_ready}} & out_grant;
  assign fire     = out_valid & out_ready;
  assign busy     = (state_q == BURST);
  assign err_size = fire & (state_q == IDLE) & oversize;

  // Beat count of the message presented on the merged port (minus one).
  always_comb begin
    size_i       = int'(out_size);
    oversize     = (size_i > MAX_SIZE);
    eff_size     = oversize ? MAX_SIZE : size_i;
    msg_beats_m1 = '0;
    if ((out_opcode == 3'd1 || out_opcode == 3'd5) && eff_size > LG_BEAT)
      msg_beats_m1 = BL_W'((1 << (eff_size - LG_BEAT)) - 1);
  end

  // Next-state: advance rr_ptr after 1-beat messages, lock for bursts.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_idx_d   = lock_idx_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (msg_beats_m1 == '0) begin
            rr_ptr_d = next_idx(win_idx);
          end else begin
            lock_idx_d   = win_idx;
            beats_left_d = msg_beats_m1;
            state_d      = BURST;
          end
        end
      end
      BURST: begin
        if (fire) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == BL_W'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(lock_idx_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any partial burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      lock_idx_q   <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_idx_q   <= lock_idx_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule
